// File: rtl/imem_loader.sv
// Byte-stream loader that writes 9-bit instructions into the instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned INSTR_W   = 9,
    parameter int unsigned MAX_INSTR = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [12:0]        count_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_INS_LO,
        S_INS_HI,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_next;
    logic [15:0] len;
    logic [7:0]  low_byte;
    logic        xfer;
    logic        do_start;
    logic        do_write;
    logic [15:0] len_full;
    logic [15:0] count_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer       = in_valid && in_ready;
    assign len_full   = {in_data, len[7:0]};
    assign count_next = {3'b000, count_loaded} + 16'd1;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_LEN_LO, S_LEN_HI, S_INS_LO, S_INS_HI: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                                  in_ready = 1'b1;
`endif
            default:                                in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_write   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN_LO;
                    do_start   = 1'b1;
                end
            end
            S_LEN_LO: if (xfer) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if ({16'd0, len_full} > MAX_INSTR)
                        state_next = S_ERR;
                    else if (len_full == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = S_CHK;
`else
                        state_next = S_DONE;
`endif
                    else
                        state_next = S_INS_LO;
                end
            end
            S_INS_LO: if (xfer) state_next = S_INS_HI;
            S_INS_HI: begin
                if (xfer) begin
                    if (in_data[7:1] != 7'd0) begin
                        state_next = S_ERR;
                    end else begin
                        do_write = 1'b1;
                        if (count_next == len)
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_next = S_CHK;
`else
                            state_next = S_DONE;
`endif
                        else
                            state_next = S_INS_LO;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer)
                    state_next = (in_data == csum) ? S_DONE : S_ERR;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status flags are registered from the next state so they line up with the state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            busy  <= (state_next != S_IDLE) && (state_next != S_DONE) && (state_next != S_ERR);
            done  <= (state_next == S_DONE);
            error <= (state_next == S_ERR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len          <= '0;
            low_byte     <= '0;
            count_loaded <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_we <= do_write;
            if (state == S_LEN_LO && xfer)
                len[7:0] <= in_data;
            if (state == S_LEN_HI && xfer)
                len[15:8] <= in_data;
            if (state == S_INS_LO && xfer)
                low_byte <= in_data;
            if (do_start)
                count_loaded <= '0;
            // The write address is simply the number of words already written.
            if (do_write) begin
                mem_waddr    <= count_loaded[ADDR_W-1:0];
                mem_wdata    <= {in_data[0], low_byte};
                count_loaded <= count_loaded + 13'd1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (do_start) begin
            csum <= '0;
        end else if (xfer && state != S_CHK) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; covers both builds of IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [8:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] count_loaded;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;

    imem_loader #(.ADDR_W(12), .INSTR_W(9), .MAX_INSTR(4096)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .count_loaded(count_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we === 1'b1) wr_count++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'h5A;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_gap(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        send(b);
    endtask

    task automatic chk_write(input string tag, input logic [11:0] a, input logic [8:0] d);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_addr"}, 32'(mem_waddr), 32'(a));
        chk({tag, "_data"}, 32'(mem_wdata), 32'(d));
    endtask

    int wr_base;

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #3;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_count", 32'(count_loaded), 32'd0);
        chk("rst_addr_data", {11'd0, mem_waddr, mem_wdata}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Abort mid-stream after three bytes
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
        send(8'h02); send(8'h00); send(8'h34);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(in_ready), 32'd0);
        chk("abort_flags", {29'd0, busy, done, error}, 32'd0);
        chk("abort_count", 32'(count_loaded), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_idle_ready", 32'(in_ready), 32'd0);

        // Two-instruction image
        wr_base = wr_count;
        do_start();
        send(8'h02); send(8'h00); send(8'h34); send(8'h01);
        chk_write("w0", 12'd0, 9'h134);
        chk("w0_count", 32'(count_loaded), 32'd1);
        chk("w0_busy", 32'(busy), 32'd1);
        send(8'hFF); send(8'h00);
        chk_write("w1", 12'd1, 9'h0FF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("w1_chk_busy", 32'(busy), 32'd1);
        send(8'hC8);
`endif
        chk("img2_flags", {29'd0, busy, done, error}, 32'b010);
        chk("img2_count", 32'(count_loaded), 32'd2);
        chk("img2_ready", 32'(in_ready), 32'd0);
        tick();
        chk("img2_we_drop", 32'(mem_we), 32'd0);
        chk("img2_hold", {11'd0, mem_waddr, mem_wdata}, {11'd0, 12'd1, 9'h0FF});
        chk("img2_writes", 32'(wr_count - wr_base), 32'd2);

        // Empty image
        wr_base = wr_count;
        do_start();
        chk("zero_cleared", {29'd0, busy, done, error}, 32'b100);
        send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        chk("zero_flags", {29'd0, busy, done, error}, 32'b010);
        chk("zero_count", 32'(count_loaded), 32'd0);
        tick();
        chk("zero_writes", 32'(wr_count - wr_base), 32'd0);

        // Length above the limit
        wr_base = wr_count;
        do_start();
        send(8'h01); send(8'h10);
        chk("big_flags", {29'd0, busy, done, error}, 32'b001);
        chk("big_ready", 32'(in_ready), 32'd0);
        tick();
        chk("big_writes", 32'(wr_count - wr_base), 32'd0);

        // Reserved bit set in the high byte
        do_start();
        chk("restart_clears_err", {29'd0, busy, done, error}, 32'b100);
        send(8'h01); send(8'h00); send(8'h12); send(8'h02);
        chk("rsv_flags", {29'd0, busy, done, error}, 32'b001);
        chk("rsv_we", 32'(mem_we), 32'd0);
        tick();
        chk("rsv_writes", 32'(wr_count - wr_base), 32'd0);

        // Gappy delivery, start pulses mid-load must be ignored
        wr_base = wr_count;
        do_start();
        send_gap(8'h03); send_gap(8'h00);
        start = 1'b1;
        send_gap(8'h11);
        start = 1'b0;
        send_gap(8'h00);
        chk_write("g0", 12'd0, 9'h011);
        send_gap(8'h22); send_gap(8'h01);
        chk_write("g1", 12'd1, 9'h122);
        send_gap(8'h33); send_gap(8'h00);
        chk_write("g2", 12'd2, 9'h033);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_gap(8'h02);
`endif
        chk("gap_flags", {29'd0, busy, done, error}, 32'b010);
        chk("gap_count", 32'(count_loaded), 32'd3);
        tick();
        chk("gap_writes", 32'(wr_count - wr_base), 32'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wr_base = wr_count;
        do_start();
        send(8'h01); send(8'h00); send(8'hAB); send(8'h01);
        chk_write("c0", 12'd0, 9'h1AB);
        send(8'hAB);
        chk("csum_ok_flags", {29'd0, busy, done, error}, 32'b010);
        do_start();
        send(8'h01); send(8'h00); send(8'hAB); send(8'h01);
        send(8'h00);
        chk("csum_bad_flags", {29'd0, busy, done, error}, 32'b001);
        chk("csum_bad_count", 32'(count_loaded), 32'd1);
        tick();
        chk("csum_writes", 32'(wr_count - wr_base), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: receives a byte stream from the host/test channel and writes 9-bit instructions into the instruction-memory write port.
- Sits between the host byte link and the imem write port.
- Holds the CPU via `busy` until a program image is fully written.
- Image format: 2-byte little-endian instruction count, then 2 bytes per instruction.
  - Low byte = instr[7:0].
  - High byte bit0 = instr[8], bits[7:1] reserved and must be zero.

Parameters:
- ADDR_W, 12, write address width (2^12 = 4096-entry soft limit).
- INSTR_W, 9, instruction width; fixed at 9, packing below assumes it.
- MAX_INSTR, 4096, largest legal instruction count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new load from IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse.
- mem_waddr  output  ADDR_W  write address.
- mem_wdata  output  INSTR_W  write data.
- busy  output  1  load in progress; CPU must hold PC at 0.
- done  output  1  image written successfully; sticky until next start.
- error  output  1  image rejected; sticky until next start.
- count_loaded  output  13  instructions written so far.

Behaviour:
- States: IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, (CHK), DONE, ERR.
- Reset (asserted low, async): state=IDLE; in_ready, mem_we, busy, done, error = 0; mem_waddr, mem_wdata, count_loaded = 0; internal length = 0. Memory contents are untouched.
- Byte transfer: occurs when in_valid && in_ready at the clk edge.
  - in_ready = 1 exactly in LEN_LO, LEN_HI, INS_LO, INS_HI, CHK; 0 otherwise.
  - in_data is ignored when no transfer occurs.
- start:
  - In IDLE, DONE or ERR: go to LEN_LO next cycle; clear done, error, count_loaded; set busy.
  - In any other state: ignored.
- LEN_LO: on transfer, latch len[7:0], go to LEN_HI.
- LEN_HI: on transfer, len = {in_data, len[7:0]}.
  - If len > MAX_INSTR → ERR.
  - Else if len == 0 → DONE (CHK when the optional feature is on).
  - Else → INS_LO with address 0.
- INS_LO: on transfer, latch low byte, go to INS_HI.
- INS_HI: on transfer:
  - If in_data[7:1] != 0 → ERR, no write.
  - Otherwise, next cycle: mem_we=1 for exactly one cycle, mem_wdata={in_data[0], low}, mem_waddr = current address. count_loaded increments on that same edge.
  - If count_loaded+1 == len → DONE (or CHK); else → INS_LO with address+1.
- Write latency: 1 cycle after the high byte is accepted. Back-to-back instruction bytes are legal, giving a maximum of one write per 2 cycles.
- Addresses start at 0 and increase by 1; with len ≤ MAX_INSTR no wrap-around occurs.
- DONE: busy=0, done=1. ERR: busy=0, error=1.
  - Words already written remain in memory.
  - done and error are never 1 together.
- mem_waddr and mem_wdata hold their last value when mem_we=0.
- Reset mid-load: abort immediately to the reset values; a partial image may remain in memory.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every data byte (length and instruction bytes) is kept.
  - After the last instruction, or after len==0, the state is CHK and one extra byte is accepted.
  - Byte equal to the running XOR → DONE; otherwise → ERR.
  - Writes already issued are not undone.
- Undefined: no CHK state; the final instruction goes directly to DONE. Zero extra logic.

Test Plan:
- Reset low mid-stream after 3 bytes → all outputs 0, state IDLE; a following start plus a clean image loads correctly.
- start; bytes 02 00 | 34 01 | FF 00 → mem_we pulses at addr 0 data 0x134 and addr 1 data 0x0FF, each 1 cycle after its high byte; then done=1, busy=0, count_loaded=2.
- start; bytes 00 00 → done=1 with no mem_we pulse (checksum build: add byte 00 → done=1).
- start; bytes 01 10 (len 4097) → error=1, no writes, in_ready=0; next start clears error.
- start; 01 00 | 12 02 (reserved bit set) → error=1, no write; separately, in_valid toggled randomly → same writes as back-to-back delivery.
- Checksum build: 01 00 | AB 01 | AB → done=1; a wrong last byte such as 00 → error=1, with the write to addr 0 already present.
